alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Sequential execute-stage ALU that consumes the 4-bit alucontrol code produced by the ALU decoder.
- Operands enter on a valid/ready handshake. The result leaves through a single-entry registered output with its own valid/ready handshake.
- 64-bit DADD/DSUB use one shared 32-bit adder over two cycles (low half, then high half with carry). All other ops complete in one cycle.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- HALF, 32, adder slice width; must be XLEN/2.
- ILLEGAL_RESULT, 64'h0, result value driven for unrecognised alucontrol codes.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  operand bundle valid
- in_ready  output  1  unit can accept a bundle this cycle
- alucontrol  input  4  operation code
- srca  input  64  operand A
- srcb  input  64  operand B
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer takes the result this cycle
- result  output  64  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow on ADD/SUB/DADD/DSUB
- illegal  output  1  alucontrol was not a recognised code

Behaviour:
- Op codes and results:
  - 0000 AND: 64-bit bitwise AND.
  - 0001 OR: 64-bit bitwise OR.
  - 0010 ADD: srca[31:0]+srcb[31:0], sign-extended to 64.
  - 0110 SUB: srca[31:0]-srcb[31:0], sign-extended to 64.
  - 0111 SLT: 1 if signed srca[31:0] < signed srcb[31:0], else 0, zero-extended.
  - 1010 DADD: 64-bit add.
  - 1110 DSUB: 64-bit subtract.
  - Any other code (including X): result=ILLEGAL_RESULT, illegal=1, overflow=0, single-cycle.
- Subtraction is implemented as A + ~B + 1 on the shared adder.
- overflow is computed on the 32-bit result for ADD/SUB and on the 64-bit result for DADD/DSUB; 0 for all other ops. No trap is raised; overflow is a flag only.
- zero reflects the registered result and is valid whenever out_valid=1.
- States: IDLE, HI, HOLD.
  - IDLE: out_valid=0, in_ready=1.
    - Accept on in_valid. A single-cycle op loads the result regs and goes to HOLD.
    - DADD/DSUB latches the low 32-bit sum, carry-out, srca[63:32], srcb[63:32] and op, then goes to HI.
  - HI: in_ready=0, out_valid=0. Computes the high half with the latched carry, loads result/overflow, goes to HOLD.
  - HOLD: out_valid=1; result/zero/overflow/illegal are stable.
    - in_ready = out_ready.
    - out_ready=1 and in_valid=1: handshake and accept in the same cycle (back-to-back). Next state is HOLD for a single-cycle op or HI for a 64-bit op.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: stay; in_ready=0.
- Latency, with acceptance at edge N:
  - single-cycle op: out_valid at N+1;
  - DADD/DSUB: out_valid at N+2.
- Throughput:
  - 1 op/cycle for single-cycle ops with out_ready held 1;
  - 1 op per 2 cycles for 64-bit ops.
- Operands are sampled only at acceptance; srca/srcb/alucontrol may change freely afterward, including during HI.
- Reset (reset=0, any state, including mid-HI):
  - Immediately: state=IDLE, out_valid=0, result=0, zero=1, overflow=0, illegal=0. in_ready=0 while reset=0.
  - The partial 64-bit op is discarded.
  - First acceptance possible on the first rising edge after reset deasserts.
- in_valid is ignored when in_ready=0; no bundle is lost or duplicated.

Test Plan:
- DADD carry across halves: srca=0x00000000_FFFFFFFF, srcb=1, code 1010 accepted at edge N → out_valid rises N+2, result=0x00000001_00000000, zero=0, overflow=0. in_ready=0 during HI.
- ADD 32-bit overflow and sign-extension: srca=0x7FFFFFFF, srcb=1, code 0010 → result=0xFFFFFFFF_80000000, overflow=1, out_valid at N+1. Then DSUB 0x8000000000000000 - 1 → result 0x7FFFFFFFFFFFFFFF, overflow=1.
- SLT, SUB and zero: SLT srca=0xFFFFFFFF, srcb=1 → result 1. SUB srca=5, srcb=5 → result 0, zero=1. Issue AND, OR, SLT back-to-back with out_ready=1 → one result per cycle, in order.
- Backpressure: out_ready=0 for 5 cycles after a result → result and flags stable, in_ready=0, the following bundle is not accepted. Raise out_ready with in_valid=1 → handshake and accept occur in the same edge.
- Illegal code: alucontrol=0011 → illegal=1, result=0, overflow=0, zero=1, out_valid at N+1. The next legal op clears illegal.
- Reset mid-operation: assert reset=0 while in HI for DADD → out_valid=0 and result=0 immediately (asynchronous). After release, a new ADD 2+3 → result 5 with no residue from the aborted op.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Sequential execute-stage ALU: 32-bit ops in one cycle, DADD/DSUB over two
// cycles on a shared HALF-bit adder, single-entry registered valid/ready output.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | output empty, ready to accept a bundle
//   HI    | 64-bit op in flight, computing high half with latched carry
//   HOLD  | result register valid, waiting for consumer handshake
module alu_exec_unit #(
    parameter int unsigned     XLEN           = 64,
    parameter int unsigned     HALF           = 32,
    parameter logic [XLEN-1:0] ILLEGAL_RESULT = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              illegal_q, illegal_d;
    logic [HALF-1:0]   lo_sum_q, lo_sum_d;
    logic              carry_q, carry_d;
    logic [HALF-1:0]   a_hi_q, a_hi_d;
    logic [HALF-1:0]   b_hi_q, b_hi_d;
    logic              sub_q, sub_d;

    logic              dec_sub;
    logic              dec_wide;
    logic [HALF-1:0]   add_a;
    logic [HALF-1:0]   add_b;
    logic              add_cin;
    logic [HALF:0]     add_sum;
    logic              add_ovf;
    logic [XLEN-1:0]   single_res;
    logic              single_ovf;
    logic              single_ill;
    logic              accept;

    always_comb begin
        dec_sub  = 1'b0;
        dec_wide = 1'b0;
        case (alucontrol)
            4'b0110, 4'b0111: dec_sub = 1'b1;
            4'b1010:          dec_wide = 1'b1;
            4'b1110: begin
                dec_sub  = 1'b1;
                dec_wide = 1'b1;
            end
            default: ;
        endcase
    end

    // The one shared adder: high half of a latched 64-bit op in HI, otherwise
    // the low half of the incoming operands. Subtract is A + ~B + 1.
    always_comb begin
        if (state_q == S_HI) begin
            add_a   = a_hi_q;
            add_b   = b_hi_q ^ {HALF{sub_q}};
            add_cin = carry_q;
        end else begin
            add_a   = srca[HALF-1:0];
            add_b   = srcb[HALF-1:0] ^ {HALF{dec_sub}};
            add_cin = dec_sub;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{HALF{1'b0}}, add_cin};
        add_ovf = (add_a[HALF-1] == add_b[HALF-1]) && (add_sum[HALF-1] != add_a[HALF-1]);
    end

    always_comb begin
        single_res = ILLEGAL_RESULT;
        single_ovf = 1'b0;
        single_ill = 1'b0;
        case (alucontrol)
            4'b0000: single_res = srca & srcb;
            4'b0001: single_res = srca | srcb;
            4'b0010, 4'b0110: begin
                single_res = {{(XLEN-HALF){add_sum[HALF-1]}}, add_sum[HALF-1:0]};
                single_ovf = add_ovf;
            end
            // Signed less-than: sign of the difference corrected by overflow
            4'b0111: single_res = {{(XLEN-1){1'b0}}, add_sum[HALF-1] ^ add_ovf};
            default: single_ill = 1'b1;
        endcase
    end

    assign in_ready  = reset && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    assign out_valid = (state_q == S_HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        lo_sum_d   = lo_sum_q;
        carry_d    = carry_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        sub_d      = sub_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    if (dec_wide) begin
                        lo_sum_d = add_sum[HALF-1:0];
                        carry_d  = add_sum[HALF];
                        a_hi_d   = srca[XLEN-1:HALF];
                        b_hi_d   = srcb[XLEN-1:HALF];
                        sub_d    = dec_sub;
                        state_d  = S_HI;
                    end else begin
                        result_d   = single_res;
                        overflow_d = single_ovf;
                        illegal_d  = single_ill;
                        state_d    = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_HI: begin
                result_d   = {add_sum[HALF-1:0], lo_sum_q};
                overflow_d = add_ovf;
                illegal_d  = 1'b0;
                state_d    = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            lo_sum_q   <= '0;
            carry_q    <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            sub_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            lo_sum_q   <= lo_sum_d;
            carry_q    <= carry_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            sub_q      <= sub_d;
        end
    end

    assign result   = result_q;
    assign zero     = (result_q == '0);
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference
// model: results, flags, latency, handshakes, backpressure and async reset.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit dut (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        longint sa, sb, s;
        logic signed [64:0] w;
        sa = longint'({{32{a[31]}}, a[31:0]});
        sb = longint'({{32{b[31]}}, b[31:0]});
        e.res = 64'h0;
        e.ovf = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010, 4'b0110: begin
                s = (op == 4'b0010) ? sa + sb : sa - sb;
                e.res = {{32{s[31]}}, s[31:0]};
                e.ovf = (s != longint'({{32{s[31]}}, s[31:0]}));
            end
            4'b0111: e.res = (sa < sb) ? 64'd1 : 64'd0;
            4'b1010, 4'b1110: begin
                if (op == 4'b1010) w = $signed({a[63], a}) + $signed({b[63], b});
                else               w = $signed({a[63], a}) - $signed({b[63], b});
                e.res = w[63:0];
                e.ovf = w[64] ^ w[63];
                e.lat = 2;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        chk({tag, "_ill"}, 64'(illegal), 64'(e.ill));
        chk({tag, "_zero"}, 64'(zero), 64'(e.res == 64'h0));
    endtask

    // Issue one op from IDLE, check latency and outputs, optionally stall the
    // consumer, then drain back to IDLE.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int stall);
        exp_t e;
        e = model(op, a, b);
        alucontrol = op;
        srca       = a;
        srcb       = b;
        in_valid   = 1'b1;
        out_ready  = (stall == 0);
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        srca       = {$urandom, $urandom};
        srcb       = {$urandom, $urandom};
        alucontrol = 4'($urandom);
        if (e.lat == 2) begin
            chk({tag, "_hi_out_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "_hi_in_ready"}, 64'(in_ready), 64'd0);
            tick();
        end
        chk_out(tag, e);
        for (int k = 0; k < stall; k++) begin
            chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
            tick();
            chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_stall_result"}, result, e.res);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        exp_t e, ea;
        logic [3:0] ops[3];
        logic [63:0] as[3], bs[3];
        logic [3:0] legal[7];

        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alucontrol = 4'h0;
        srca       = 64'h0;
        srcb       = 64'h0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'h0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ill", 64'(illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        rst = 1'b1;

        do_op("dadd_carry", 4'b1010, 64'h00000000_FFFFFFFF, 64'h1, 0);
        chk("dadd_carry_model", model(4'b1010, 64'h00000000_FFFFFFFF, 64'h1).res, 64'h00000001_00000000);
        do_op("add_ovf", 4'b0010, 64'h7FFFFFFF, 64'h1, 0);
        do_op("dsub_ovf", 4'b1110, 64'h80000000_00000000, 64'h1, 0);
        do_op("slt", 4'b0111, 64'hFFFFFFFF, 64'h1, 0);
        do_op("sub_zero", 4'b0110, 64'h5, 64'h5, 0);
        do_op("illegal", 4'b0011, 64'h1234, 64'h5678, 0);
        do_op("illegal_x", 4'bxxxx, 64'h1, 64'h1, 1);
        do_op("legal_clear", 4'b0001, 64'hF0, 64'h0F, 0);

        // Back-to-back single-cycle ops, one result per cycle
        ops[0] = 4'b0000; as[0] = 64'hFF00FF00_12345678; bs[0] = 64'h0FF00FF0_FFFF0000;
        ops[1] = 4'b0001; as[1] = 64'h00000000_000000F0; bs[1] = 64'h80000000_0000000F;
        ops[2] = 4'b0111; as[2] = 64'h00000000_80000000; bs[2] = 64'h00000000_7FFFFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alucontrol = ops[i];
            srca       = as[i];
            srcb       = bs[i];
            in_valid   = 1'b1;
            #1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            tick();
            e = model(ops[i], as[i], bs[i]);
            chk_out("b2b", e);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // Backpressure, then handshake + accept of a 64-bit op on the same edge
        out_ready  = 1'b0;
        alucontrol = 4'b0010;
        srca       = 64'h0000_0000_1111_2222;
        srcb       = 64'h0000_0000_3333_4444;
        in_valid   = 1'b1;
        ea = model(4'b0010, srca, srcb);
        tick();
        alucontrol = 4'b1110;
        srca       = 64'h80000000_00000000;
        srcb       = 64'h1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk_out("bp_hold", ea);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        srca       = {$urandom, $urandom};
        alucontrol = 4'($urandom);
        chk("bp_hi_out_valid", 64'(out_valid), 64'd0);
        chk("bp_hi_in_ready", 64'(in_ready), 64'd0);
        tick();
        e.res = 64'h7FFFFFFF_FFFFFFFF; e.ovf = 1'b1; e.ill = 1'b0; e.lat = 2;
        chk_out("bp_dsub", e);
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a 64-bit op
        do_op("pre_rst", 4'b1010, 64'h00000000_FFFFFFFF, 64'h1, 0);
        alucontrol = 4'b1010;
        srca       = 64'hFFFFFFFF_FFFFFFFF;
        srcb       = 64'h1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_hi_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_result", result, 64'h0);
        chk("async_rst_zero", 64'(zero), 64'd1);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("rst_held_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        do_op("post_rst_add", 4'b0010, 64'd2, 64'd3, 0);

        // Random ops with random consumer stalls
        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1010, 4'b1110};
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [63:0] a, b;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 6)];
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a[31] = ~a[31];
            do_op("rand", op, a, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
